// File: rtl/runway_allocator.sv
// Runway allocator: tracks runway occupancy and owners,
// self-selects free open runways, optional auto-release.
module runway_allocator #(
  parameter int NUM_RUNWAYS = 4,
  parameter int ID_WIDTH    = 4,
  parameter int TIMEOUT     = 0,
  parameter int RR_MODE     = 0,
  localparam int RW_W = (NUM_RUNWAYS > 1) ? $clog2(NUM_RUNWAYS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_req,
  input  logic [ID_WIDTH-1:0]    alloc_id,
  input  logic                   release_req,
  input  logic [ID_WIDTH-1:0]    release_id,
  input  logic [RW_W-1:0]        release_rw,
  input  logic [NUM_RUNWAYS-1:0] closed,
  output logic                   alloc_done,
  output logic                   alloc_ok,
  output logic [RW_W-1:0]        alloc_rw,
  output logic                   release_done,
  output logic                   release_ok,
  output logic [NUM_RUNWAYS-1:0] timeout_vec,
  output logic [NUM_RUNWAYS-1:0] runway_active,
  output logic                   all_busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [NUM_RUNWAYS-1:0] occ;
  logic [ID_WIDTH-1:0]    owner [NUM_RUNWAYS];
  logic [RW_W-1:0]        rr_ptr;

  logic [NUM_RUNWAYS-1:0] elig;
  logic [NUM_RUNWAYS-1:0] rel_hit;
  logic [NUM_RUNWAYS-1:0] to_hit;
  logic [NUM_RUNWAYS-1:0] gnt_vec;
  logic                   dup;
  logic                   found;
  logic                   gnt;
  logic [RW_W-1:0]        pick;
  logic [RW_W-1:0]        rr_next;

  assign elig          = ~occ & ~closed;
  assign runway_active = occ;
  assign all_busy      = ~|elig;
  assign gnt           = alloc_req & ~dup & found;
  assign rr_next       = (pick == RW_W'(NUM_RUNWAYS - 1)) ?
                         '0 : pick + 1'b1;

  // A plane may hold at most one runway at a time
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_RUNWAYS; i++) begin
      if (occ[i] && owner[i] == alloc_id) dup = 1'b1;
    end
  end

  // First eligible runway, from 0 or from the RR pointer
  always_comb begin
    int idx;
    logic [RW_W-1:0] sel;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_RUNWAYS; k++) begin
      if (RR_MODE != 0) idx = (int'(rr_ptr) + k) % NUM_RUNWAYS;
      else              idx = k;
      sel = RW_W'(idx);
      if (!found && elig[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  // Decode grant and release into per-runway strobes
  always_comb begin
    gnt_vec = '0;
    rel_hit = '0;
    for (int i = 0; i < NUM_RUNWAYS; i++) begin
      gnt_vec[i] = gnt && pick == RW_W'(i);
      rel_hit[i] = release_req && release_rw == RW_W'(i) &&
                   occ[i] && owner[i] == release_id;
    end
  end

  if (TIMEOUT > 0) begin : g_to
    logic [CW-1:0] cnt [NUM_RUNWAYS];

    // Occupancy age, restarted on grant, saturating
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < NUM_RUNWAYS; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_RUNWAYS; i++) begin
          if (gnt_vec[i])
            cnt[i] <= '0;
          else if (occ[i] && cnt[i] != CW'(TIMEOUT))
            cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end

    // Runway expires on the edge where its age hits TIMEOUT-1
    always_comb begin
      to_hit = '0;
      for (int i = 0; i < NUM_RUNWAYS; i++) begin
        to_hit[i] = occ[i] && cnt[i] == CW'(TIMEOUT - 1);
      end
    end
  end else begin : g_no_to
    assign to_hit = '0;
  end

  // Occupancy, owners, RR pointer and registered responses
  always_ff @(posedge clock) begin
    if (reset) begin
      occ          <= '0;
      rr_ptr       <= '0;
      alloc_done   <= 1'b0;
      alloc_ok     <= 1'b0;
      alloc_rw     <= '0;
      release_done <= 1'b0;
      release_ok   <= 1'b0;
      timeout_vec  <= '0;
      for (int i = 0; i < NUM_RUNWAYS; i++) owner[i] <= '0;
    end else begin
      alloc_done   <= alloc_req;
      alloc_ok     <= gnt;
      alloc_rw     <= gnt ? pick : '0;
      release_done <= release_req;
      release_ok   <= |rel_hit;
      timeout_vec  <= to_hit & ~rel_hit;
      occ          <= (occ & ~rel_hit & ~to_hit) | gnt_vec;
      for (int i = 0; i < NUM_RUNWAYS; i++) begin
        if (gnt_vec[i]) owner[i] <= alloc_id;
      end
      if (gnt && RR_MODE != 0) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_runway_allocator.sv
// Bench for runway_allocator: two configurations driven in
// lockstep, checked against a grant-time based reference.
module tb_runway_allocator;

  logic       clock = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [3:0] alloc_id;
  logic       release_req;
  logic [3:0] release_id;
  logic [1:0] release_rw;
  logic [3:0] closed;

  logic       ad  [2];
  logic       aok [2];
  logic [1:0] arw [2];
  logic       rd  [2];
  logic       rok [2];
  logic [3:0] tv  [2];
  logic [3:0] act [2];
  logic       ab  [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  runway_allocator #(
    .NUM_RUNWAYS(4), .ID_WIDTH(4), .TIMEOUT(0), .RR_MODE(0)
  ) dut0 (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_id(alloc_id),
    .release_req(release_req), .release_id(release_id),
    .release_rw(release_rw), .closed(closed),
    .alloc_done(ad[0]), .alloc_ok(aok[0]), .alloc_rw(arw[0]),
    .release_done(rd[0]), .release_ok(rok[0]),
    .timeout_vec(tv[0]), .runway_active(act[0]),
    .all_busy(ab[0])
  );

  runway_allocator #(
    .NUM_RUNWAYS(4), .ID_WIDTH(4), .TIMEOUT(8), .RR_MODE(1)
  ) dut1 (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_id(alloc_id),
    .release_req(release_req), .release_id(release_id),
    .release_rw(release_rw), .closed(closed),
    .alloc_done(ad[1]), .alloc_ok(aok[1]), .alloc_rw(arw[1]),
    .release_done(rd[1]), .release_ok(rok[1]),
    .timeout_vec(tv[1]), .runway_active(act[1]),
    .all_busy(ab[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: occupancy plus the cycle each plane landed on it
  int         cyc = 0;
  logic       m_occ [2][4];
  logic [3:0] m_own [2][4];
  int         m_g   [2][4];
  int         m_rr  [2];

  logic       e_ad  [2];
  logic       e_aok [2];
  logic [1:0] e_arw [2];
  logic       e_rd  [2];
  logic       e_rok [2];
  logic [3:0] e_tv  [2];
  logic [3:0] e_act [2];
  logic       e_ab  [2];

  task automatic model(input int d);
    int  tmo, start, pick, idx;
    bit  dup, relok, grant;
    tmo = (d == 1) ? 8 : 0;
    e_tv[d] = 4'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_occ[d][i] = 1'b0;
        m_own[d][i] = 4'd0;
      end
      m_rr[d]  = 0;
      e_ad[d]  = 1'b0;
      e_aok[d] = 1'b0;
      e_arw[d] = 2'd0;
      e_rd[d]  = 1'b0;
      e_rok[d] = 1'b0;
      e_act[d] = 4'b0;
      e_ab[d]  = &closed;
      return;
    end
    dup = 0;
    for (int i = 0; i < 4; i++)
      if (m_occ[d][i] && m_own[d][i] == alloc_id) dup = 1;
    start = (d == 1) ? m_rr[d] : 0;
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (start + k) % 4;
      if (pick < 0 && !m_occ[d][idx] && !closed[idx]) pick = idx;
    end
    relok = release_req && m_occ[d][release_rw] &&
            m_own[d][release_rw] == release_id;
    for (int i = 0; i < 4; i++) begin
      if (tmo > 0 && m_occ[d][i] && cyc - m_g[d][i] == tmo) begin
        if (!(relok && int'(release_rw) == i)) e_tv[d][i] = 1'b1;
        m_occ[d][i] = 1'b0;
      end
    end
    if (relok) m_occ[d][release_rw] = 1'b0;
    grant = alloc_req && !dup && pick >= 0;
    if (grant) begin
      m_occ[d][pick] = 1'b1;
      m_own[d][pick] = alloc_id;
      m_g[d][pick]   = cyc;
      if (d == 1) m_rr[d] = (pick + 1) % 4;
    end
    e_ad[d]  = alloc_req;
    e_aok[d] = grant;
    e_arw[d] = grant ? 2'(pick) : 2'd0;
    e_rd[d]  = release_req;
    e_rok[d] = relok;
    for (int i = 0; i < 4; i++) e_act[d][i] = m_occ[d][i];
    e_ab[d] = ~|(~e_act[d] & ~closed);
  endtask

  task automatic step();
    model(0);
    model(1);
    cyc++;
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d alloc_done", d), 32'(ad[d]), 32'(e_ad[d]));
      chk($sformatf("d%0d alloc_ok", d), 32'(aok[d]), 32'(e_aok[d]));
      chk($sformatf("d%0d alloc_rw", d), 32'(arw[d]), 32'(e_arw[d]));
      chk($sformatf("d%0d release_done", d), 32'(rd[d]), 32'(e_rd[d]));
      chk($sformatf("d%0d release_ok", d), 32'(rok[d]), 32'(e_rok[d]));
      chk($sformatf("d%0d timeout_vec", d), 32'(tv[d]), 32'(e_tv[d]));
      chk($sformatf("d%0d runway_active", d), 32'(act[d]), 32'(e_act[d]));
      chk($sformatf("d%0d all_busy", d), 32'(ab[d]), 32'(e_ab[d]));
    end
  endtask

  task automatic idle();
    reset       = 1'b0;
    alloc_req   = 1'b0;
    release_req = 1'b0;
  endtask

  task automatic do_alloc(input logic [3:0] id);
    idle();
    alloc_req = 1'b1;
    alloc_id  = id;
    step();
  endtask

  task automatic do_rel(input logic [3:0] id, input logic [1:0] rw);
    idle();
    release_req = 1'b1;
    release_id  = id;
    release_rw  = rw;
    step();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle();
    alloc_id   = 4'd0;
    release_id = 4'd0;
    release_rw = 2'd0;
    closed     = 4'b0;
    do_reset();
    chk("reset active", 32'(act[0]), 32'h0);
    chk("reset done", 32'(ad[0]), 32'h0);

    // lowest-index grants
    do_alloc(4'd3);
    chk("t1 rw first", 32'(arw[0]), 32'd0);
    do_alloc(4'd5);
    chk("t1 rw second", 32'(arw[0]), 32'd1);
    chk("t1 active", 32'(act[0]), 32'b0011);

    // duplicate id and wrong-owner release
    do_alloc(4'd3);
    chk("t2 dup", 32'(aok[0]), 32'd0);
    do_rel(4'd9, 2'd0);
    chk("t2 bad rel", 32'(rok[0]), 32'd0);
    do_rel(4'd3, 2'd0);
    chk("t2 rel", 32'(rok[0]), 32'd1);
    chk("t2 active0", 32'(act[0][0]), 32'd0);

    // closures
    do_reset();
    do_alloc(4'd3);
    closed = 4'b1110;
    do_alloc(4'd5);
    chk("t3 closed rej", 32'(aok[0]), 32'd0);
    chk("t3 all_busy", 32'(ab[0]), 32'd1);
    closed = 4'b0;
    do_alloc(4'd5);
    chk("t3 reopen rw", 32'(arw[0]), 32'd1);

    // round-robin on dut1
    do_reset();
    do_alloc(4'd1);
    do_alloc(4'd2);
    do_rel(4'd1, 2'd0);
    do_alloc(4'd3);
    chk("t4 rr rw2", 32'(arw[1]), 32'd2);
    do_rel(4'd2, 2'd1);
    do_alloc(4'd4);
    chk("t4 rr rw3", 32'(arw[1]), 32'd3);

    // timeout on dut1
    do_reset();
    do_alloc(4'd7);
    for (int i = 0; i < 7; i++) begin
      idle();
      step();
    end
    chk("t5 pre pulse", 32'(tv[1]), 32'b0000);
    idle();
    step();
    chk("t5 pulse", 32'(tv[1]), 32'b0001);
    chk("t5 freed", 32'(act[1][0]), 32'd0);
    do_alloc(4'd8);
    chk("t5 rw", 32'(arw[1]), 32'd1);
    for (int i = 0; i < 7; i++) begin
      idle();
      step();
    end
    do_rel(4'd8, 2'd1);
    chk("t5 rel wins", 32'(rok[1]), 32'd1);
    chk("t5 no pulse", 32'(tv[1]), 32'b0000);

    // simultaneous release and alloc, then reset mid-grant
    do_reset();
    for (int i = 1; i <= 4; i++) do_alloc(4'(i));
    idle();
    alloc_req   = 1'b1;
    alloc_id    = 4'd9;
    release_req = 1'b1;
    release_id  = 4'd1;
    release_rw  = 2'd0;
    step();
    chk("t6 alloc rej", 32'(aok[0]), 32'd0);
    chk("t6 rel ok", 32'(rok[0]), 32'd1);
    idle();
    alloc_req = 1'b1;
    alloc_id  = 4'd10;
    reset     = 1'b1;
    step();
    chk("t6 reset done", 32'(ad[0]), 32'd0);
    chk("t6 reset active", 32'(act[0]), 32'd0);
    idle();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      idle();
      reset       = ($urandom_range(0, 49) == 0);
      alloc_req   = $urandom_range(0, 1) == 1;
      alloc_id    = 4'($urandom_range(0, 6));
      release_req = $urandom_range(0, 1) == 1;
      release_rw  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0)
        release_id = m_own[n % 2][release_rw];
      else
        release_id = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0)
        closed = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0)
        closed = 4'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
